gf180mcu_fd_sc_mcu7t5v0__tribus_arb: RTL and testbench
======================================================

GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__tribus_arb

Interface
REQ-001: Parameter N, default 4; number of tristate drivers (invz cells) sharing one bus, legal range 2..8.
REQ-002: Parameter DEAD, default 2; number of all-disabled turnaround cycles between bus owners, legal range 1..15.
REQ-003: Parameter MAX_HOLD, default 16; maximum owner tenure in cycles when others wait, legal range 2..255.
REQ-004: CLK  input  1  single clock; all state updates on the rising edge.
REQ-005: RST  input  1  synchronous, active-high reset.
REQ-006: REQ  input  N  per-driver bus request, level-sensitive.
REQ-007: EN  output  N  registered tristate enables, one bit per driver's EN pin.
REQ-008: OWNER  output  3  index of the current owner; valid only while BUSY=1.
REQ-009: BUSY  output  1  high while any EN bit is high.
REQ-010: TOUT  output  1  one-cycle pulse on a forced release.

Function
REQ-011: The block SHALL implement a 3-state FSM with states IDLE, DRIVE and TURN.
REQ-012: EN SHALL be zero or one-hot on every cycle, with no two bits ever high together, and SHALL come directly from flops.
REQ-013: The round-robin winner SHALL be the first set REQ bit when searching upward from pointer PTR, modulo N.
REQ-014: In IDLE with REQ!=0 at edge t, the FSM SHALL enter DRIVE, and EN[winner] SHALL be 1 after edge t (1-cycle latency).
REQ-015: On each grant, PTR SHALL become (winner+1) mod N.
REQ-016: In DRIVE, when REQ[OWNER]=0 is sampled, EN SHALL clear at that edge and the FSM SHALL enter TURN.
REQ-017: In TURN, EN SHALL stay 0 for exactly DEAD cycles.
REQ-018: On the final TURN cycle, if REQ!=0, the FSM SHALL go directly to DRIVE with the new winner; otherwise it SHALL go to IDLE.
REQ-019: Requests that rise or fall during TURN SHALL be ignored until the final TURN cycle.
REQ-020: If the owner re-requests during TURN, it SHALL compete normally; with PTR already advanced, it has lowest priority.
REQ-021: If REQ[OWNER] drops in the same cycle that the timeout fires, the timeout SHALL be ignored: release is normal and TOUT=0.
REQ-022: If only the owner requests, it SHALL hold the bus indefinitely with no forced release.
REQ-023: BUSY SHALL equal the OR-reduce of EN; OWNER SHALL hold the last owner's index while BUSY=0.

Reset
REQ-024: While RST=1 at an edge, the block SHALL set state=IDLE, EN=0, BUSY=0, OWNER=0, TOUT=0, PTR=0, turn counter=0 and hold counter=0.
REQ-025: Reset SHALL override all in-flight activity, including mid-DRIVE and mid-TURN, with EN=0 after the reset edge.
REQ-026: After reset is released, the first grant SHALL come no earlier than one edge after the first sampled REQ.

Configuration
REQ-027: Macro GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN SHALL select whether forced release is compiled in.
REQ-028: With the macro defined: an 8-bit hold counter counts EN-high cycles; once EN[OWNER] has been high MAX_HOLD cycles and any other REQ bit is set, EN SHALL clear at the next edge, TOUT SHALL pulse 1 cycle, and the FSM SHALL enter TURN.
REQ-029: With the macro defined, the hold counter SHALL clear on every grant.
REQ-030: Without the macro, the hold counter logic SHALL be absent, TOUT SHALL be tied 0, and the owner SHALL release only by dropping REQ.

Verification
REQ-031: Single request (N=4, DEAD=2): REQ=0010 at edge 1 -> EN=0010 and OWNER=1 after edge 1; REQ=0 at edge 5 -> EN=0 after edge 5; IDLE after edge 7.
REQ-032: Handover: REQ=0011 held; owner 0 drops REQ[0] at edge 4 -> EN=0000 for exactly 2 cycles, then EN=0010.
REQ-033: Fairness: REQ=1111 with each owner releasing after 3 cycles -> grant order 0,1,2,3,0, with a DEAD gap between each.
REQ-034: Timeout (macro on, MAX_HOLD=16): owner 2 holds and REQ[3]=1 -> EN[2] high exactly 16 cycles, TOUT=1 for 1 cycle, 2 dead cycles, then EN=1000.
REQ-035: Reset mid-DRIVE: EN=0100, RST=1 at edge k -> EN=0, BUSY=0, PTR=0 after edge k; the next REQ=1111 grants driver 0.
REQ-036: Throughout all tests, an assertion SHALL check that popcount(EN)<=1 every cycle and that no EN bit is high during TURN.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tribus_arb.sv
// Round-robin arbiter for N tristate drivers sharing one bus, with DEAD-cycle turnaround.
// Define GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN to compile in forced release after MAX_HOLD cycles.
module gf180mcu_fd_sc_mcu7t5v0__tribus_arb #(
    parameter int unsigned N        = 4,
    parameter int unsigned DEAD     = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    output logic [N-1:0] EN,
    output logic [2:0]   OWNER,
    output logic         BUSY,
    output logic         TOUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [N-1:0] en_q, en_n;
    logic [2:0]   owner_q, owner_n;
    logic [2:0]   ptr, ptr_n;
    logic [3:0]   turn_cnt, turn_n;

    logic [2:0]   win;
    logic         found;
    logic [N-1:0] win_mask;
    logic         own_req;
    logic         others_req;
    logic         do_grant;
    int unsigned  j;

    // Search upward from ptr, wrapping modulo N.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && (|(REQ & (ONE << j)))) begin
                found = 1'b1;
                win   = 3'(j);
            end
        end
    end

    assign win_mask   = ONE << win;
    // en_q is one-hot on the owner while driving, so masking REQ with it selects REQ[OWNER].
    assign own_req    = |(REQ & en_q);
    assign others_req = |(REQ & ~en_q);

`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_n;
    logic       tout_q, tout_n;
    logic       timeout;

    assign timeout = (state == DRIVE) && own_req && others_req &&
                     (hold_cnt >= 8'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_n  = state;
        en_n     = en_q;
        owner_n  = owner_q;
        ptr_n    = ptr;
        turn_n   = turn_cnt;
        do_grant = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
        hold_n   = hold_cnt;
        tout_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|REQ) do_grant = 1'b1;
            end
            DRIVE: begin
                if (!own_req) begin
                    state_n = TURN;
                    en_n    = '0;
                    turn_n  = '0;
                end
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_n = TURN;
                    en_n    = '0;
                    turn_n  = '0;
                    tout_n  = 1'b1;
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + 8'd1;
                end
`endif
            end
            TURN: begin
                if (turn_cnt == 4'(DEAD - 1)) begin
                    if (|REQ) do_grant = 1'b1;
                    else      state_n  = IDLE;
                end else begin
                    turn_n = turn_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = '0;
            end
        endcase

        if (do_grant) begin
            state_n = DRIVE;
            en_n    = win_mask;
            owner_n = win;
            ptr_n   = (win == 3'(N - 1)) ? 3'd0 : win + 3'd1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
            hold_n  = '0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            en_q     <= '0;
            owner_q  <= '0;
            ptr      <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            en_q     <= en_n;
            owner_q  <= owner_n;
            ptr      <= ptr_n;
            turn_cnt <= turn_n;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt <= '0;
            tout_q   <= 1'b0;
        end else begin
            hold_cnt <= hold_n;
            tout_q   <= tout_n;
        end
    end

    assign TOUT = tout_q;
`else
    assign TOUT = 1'b0;
`endif

    assign EN    = en_q;
    assign BUSY  = |en_q;
    assign OWNER = owner_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__tribus_arb.sv
// Scoreboard bench for the tristate bus arbiter: directed REQ vectors with hand-derived
// per-cycle EN/OWNER/TOUT expectations, checked by an independent negedge monitor.
module tb_gf180mcu_fd_sc_mcu7t5v0__tribus_arb;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] EN;
    logic [2:0] OWNER;
    logic       BUSY;
    logic       TOUT;

    gf180mcu_fd_sc_mcu7t5v0__tribus_arb #(
        .N(4),
        .DEAD(2),
        .MAX_HOLD(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .REQ(REQ),
        .EN(EN),
        .OWNER(OWNER),
        .BUSY(BUSY),
        .TOUT(TOUT)
    );

    typedef struct {
        string      name;
        int         idx;
        logic [3:0] en;
        logic [2:0] owner;
        logic       tout;
    } exp_t;

    exp_t  q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    step_idx   = 0;
    string test_name  = "init";

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Apply inputs, let one edge act on them, then queue what that edge must produce.
    task automatic step(input logic rst, input logic [3:0] req,
                        input logic [3:0] en, input logic [2:0] owner, input logic tout);
        exp_t e;
        RST = rst;
        REQ = req;
        @(posedge CLK);
        e.name  = test_name;
        e.idx   = step_idx;
        e.en    = en;
        e.owner = owner;
        e.tout  = tout;
        q.push_back(e);
        step_idx++;
        #1;
    endtask

    task automatic rep(input int n, input logic [3:0] req,
                       input logic [3:0] en, input logic [2:0] owner, input logic tout);
        for (int k = 0; k < n; k++) step(1'b0, req, en, owner, tout);
    endtask

    task automatic do_reset(input string name);
        test_name = name;
        step_idx  = 0;
        step(1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (EN !== e.en || BUSY !== (|e.en) || OWNER !== e.owner || TOUT !== e.tout) begin
                mismatched++;
                $display("FAIL %s[%0d]: got EN=%b BUSY=%b OWNER=%0d TOUT=%b, want EN=%b BUSY=%b OWNER=%0d TOUT=%b",
                         e.name, e.idx, EN, BUSY, OWNER, TOUT, e.en, |e.en, e.owner, e.tout);
            end
        end
        compared++;
        if (!$onehot0(EN) || (dut.state == 2'd2 && EN != 4'b0000)) begin
            mismatched++;
            $display("FAIL en_invariant: got EN=%b state=%0d, want popcount<=1 and EN=0 in TURN",
                     EN, dut.state);
        end
    end

    initial begin
        RST = 1'b1;
        REQ = 4'b0000;

        // Single request, release, and return to idle.
        do_reset("single");
        step(1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0);
        rep(3, 4'b0010, 4'b0010, 3'd1, 1'b0);
        rep(3, 4'b0000, 4'b0000, 3'd1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0);

        // Handover 0 -> 1; a REQ glitch in the middle of TURN is ignored.
        do_reset("handover");
        rep(3, 4'b0011, 4'b0001, 3'd0, 1'b0);
        step(1'b0, 4'b0010, 4'b0000, 3'd0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0);
        step(1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0);
        step(1'b0, 4'b0010, 4'b0010, 3'd1, 1'b0);

        // Fairness: every owner releases after 3 cycles and re-requests during TURN.
        do_reset("fairness");
        for (int k = 0; k < 5; k++) begin
            logic [3:0] bit_k;
            logic [2:0] o;
            o     = 3'(k % 4);
            bit_k = 4'b0001 << o;
            rep(3, 4'b1111, bit_k, o, 1'b0);
            step(1'b0, 4'b1111 & ~bit_k, 4'b0000, o, 1'b0);
            step(1'b0, 4'b1111, 4'b0000, o, 1'b0);
        end

`ifdef GF180MCU_FD_SC_MCU7T5V0__TRIBUS_ARB_TIMEOUT_EN
        // Forced release after 16 cycles, then a drop coinciding with the timeout.
        do_reset("timeout");
        step(1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0);
        rep(15, 4'b1100, 4'b0100, 3'd2, 1'b0);
        step(1'b0, 4'b1100, 4'b0000, 3'd2, 1'b1);
        step(1'b0, 4'b1100, 4'b0000, 3'd2, 1'b0);
        step(1'b0, 4'b1100, 4'b1000, 3'd3, 1'b0);
        test_name = "timeout_drop";
        rep(15, 4'b1100, 4'b1000, 3'd3, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 3'd3, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 3'd3, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0);
`else
        // Without forced release the owner keeps the bus despite a waiting driver.
        do_reset("no_timeout");
        step(1'b0, 4'b0100, 4'b0100, 3'd2, 1'b0);
        rep(30, 4'b1100, 4'b0100, 3'd2, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 3'd2, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 3'd2, 1'b0);
        step(1'b0, 4'b1000, 4'b1000, 3'd3, 1'b0);
`endif

        // Sole requester holds the bus with no forced release.
        do_reset("sole_owner");
        rep(40, 4'b0001, 4'b0001, 3'd0, 1'b0);

        // Reset mid-DRIVE: pointer returns to 0, so driver 0 wins from 1111.
        do_reset("reset_drive");
        rep(2, 4'b0100, 4'b0100, 3'd2, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 3'd0, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, 3'd0, 1'b0);

        // Reset mid-TURN.
        do_reset("reset_turn");
        step(1'b0, 4'b0001, 4'b0001, 3'd0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0);
        step(1'b1, 4'b1011, 4'b0000, 3'd0, 1'b0);
        step(1'b0, 4'b1011, 4'b0001, 3'd0, 1'b0);

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
